// File: rtl/bus_rx_flow_pkg.sv
// Shared types and constants for the I3C receive data-flow controller.
package bus_rx_flow_pkg;

  localparam int unsigned BitsPerByte = 8;
  localparam int unsigned CntW        = $clog2(BitsPerByte);

  typedef enum logic [2:0] {
    Idle,
    RxByte,
    RxBit,
    NextTaskDecision
  } rx_state_e;

  function automatic logic odd_parity(input logic [BitsPerByte-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/bus_rx_flow_bus_rx.sv
// SCL-high sample-event detection, SDA capture and one-entry bit buffer.
module bus_rx
  import bus_rx_flow_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_stable_high_i,
  input  logic sda_i,
  input  logic en_i,
  input  logic consume_i,
  output logic bit_valid_o,
  output logic bit_value_o
);

  logic scl_q;
  logic sample_event;

  assign sample_event = scl_stable_high_i & ~scl_q;

  // Reset scl_q high so an SCL level already high out of reset is not an event.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_q       <= 1'b1;
      bit_valid_o <= 1'b0;
      bit_value_o <= 1'b0;
    end else begin
      scl_q <= scl_stable_high_i;
      if (!en_i) begin
        bit_valid_o <= 1'b0;
      end else if (sample_event) begin
        bit_valid_o <= 1'b1;
        bit_value_o <= sda_i;
      end else if (consume_i) begin
        bit_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bus_rx_flow.sv
// I3C receive data-flow controller: captures a byte (MSB first) or a single bit.
// Optional odd parity on rx_data_o when BUS_RX_FLOW_PARITY_EN is defined.
module bus_rx_flow
  import bus_rx_flow_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       scl_stable_high_i,
  input  logic       sda_i,
  input  logic       req_byte_i,
  input  logic       req_bit_i,
  output logic [7:0] rx_data_o,
  output logic       rx_parity_o,
  output logic       bus_rx_done_o,
  output logic       bus_rx_idle_o,
  output logic       req_error_o
);

  localparam logic [CntW-1:0] CntLoad = CntW'(BitsPerByte - 1);

  rx_state_e              state_q;
  logic [CntW-1:0]        bit_cnt_q;
  logic [BitsPerByte-1:0] shift_q;
  logic [BitsPerByte-1:0] shift_next;
  logic [BitsPerByte-1:0] rx_data_q;
  logic                   done_q;
  logic                   idle_q;
  logic                   req_valid;
  logic                   consume;
  logic                   bit_valid;
  logic                   bit_value;

  assign req_error_o = req_byte_i & req_bit_i;
  assign req_valid   = req_byte_i ^ req_bit_i;
  assign consume     = (state_q == RxByte) || (state_q == RxBit);
  assign shift_next  = {shift_q[BitsPerByte-2:0], bit_value};

  bus_rx u_bus_rx (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .scl_stable_high_i (scl_stable_high_i),
    .sda_i             (sda_i),
    .en_i              (req_valid),
    .consume_i         (consume),
    .bit_valid_o       (bit_valid),
    .bit_value_o       (bit_value)
  );

`ifdef BUS_RX_FLOW_PARITY_EN
  logic parity_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      parity_q <= 1'b0;
    end else if (req_valid && bit_valid) begin
      if (state_q == RxByte && bit_cnt_q == '0) begin
        parity_q <= odd_parity(shift_next);
      end else if (state_q == RxBit) begin
        parity_q <= ~bit_value;
      end
    end
  end
  assign rx_parity_o = parity_q;
`else
  assign rx_parity_o = 1'b0;
`endif

  // Losing a valid request (none or both) aborts from any state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= Idle;
      bit_cnt_q <= CntLoad;
      shift_q   <= '0;
      rx_data_q <= '0;
      done_q    <= 1'b0;
      idle_q    <= 1'b1;
    end else begin
      done_q <= 1'b0;
      if (!req_valid) begin
        state_q   <= Idle;
        bit_cnt_q <= CntLoad;
        shift_q   <= '0;
        idle_q    <= 1'b1;
      end else begin
        case (state_q)
          Idle: begin
            state_q <= req_byte_i ? RxByte : RxBit;
            idle_q  <= 1'b0;
          end
          RxByte: begin
            if (bit_valid) begin
              shift_q <= shift_next;
              if (bit_cnt_q == '0) begin
                rx_data_q <= shift_next;
                done_q    <= 1'b1;
                bit_cnt_q <= CntLoad;
                state_q   <= NextTaskDecision;
              end else begin
                bit_cnt_q <= bit_cnt_q - CntW'(1);
              end
            end
          end
          RxBit: begin
            if (bit_valid) begin
              rx_data_q <= {{(BitsPerByte-1){1'b0}}, bit_value};
              done_q    <= 1'b1;
              state_q   <= NextTaskDecision;
            end
          end
          NextTaskDecision: begin
            state_q   <= req_byte_i ? RxByte : RxBit;
            bit_cnt_q <= CntLoad;
            idle_q    <= 1'b0;
          end
          default: begin
            state_q <= Idle;
            idle_q  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign rx_data_o     = rx_data_q;
  assign bus_rx_done_o = done_q;
  assign bus_rx_idle_o = idle_q;

endmodule
